// File: rtl/m3_motor_pkg.sv
// rtl/m3_motor_pkg.sv - shared state encoding, default constants and power helper
//
// Purpose: common definitions for the 3-phase step/ramp controller.
//   m3State_t  : controller state, encoded as seen on m3stateO
//   DEF_*      : default parameter values for m3_step_ramp_ctrl
//   satPower() : fixed-delta saturating add/sub for the power level
package m3_motor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_REVERSE = 2'd2,
    ST_STOP    = 2'd3
  } m3State_t;

  localparam int DEF_PERIOD_W   = 22;
  localparam int DEF_PERIOD_MAX = 4000000;
  localparam int SIM_PERIOD_MAX = 400;
  localparam int DEF_PERIOD_MIN = 40;
  localparam int DEF_STEPS      = 12;
  localparam int DEF_STEP_W     = 4;
  localparam int DEF_RAMP_SHIFT = 5;
  localparam int DEF_POWER_W    = 10;
  localparam int DEF_POWER_INIT = 102;
  localparam int DEF_POWER_MAX  = 1023;
  localparam int DEF_POWER_STEP = 8;

  // Opposing requests cancel; otherwise move by delta and clamp to [0, ceil].
  function automatic int satPower(int lvl, logic up, logic dn, int delta, int ceil);
    if (up && !dn) begin
      return (lvl + delta > ceil) ? ceil : lvl + delta;
    end
    if (dn && !up) begin
      return (lvl < delta) ? 0 : lvl - delta;
    end
    return lvl;
  endfunction

endpackage

// File: rtl/m3_sat_ramp_step.sv
// rtl/m3_sat_ramp_step.sv - saturating proportional ramp step
//
// Purpose: yO = xI +/- max(xI >> SHIFT, 1), clamped to [MIN, MAX].
//   xI   : current value
//   addI : request an increase
//   subI : request a decrease (addI and subI together cancel)
//   yO   : next value (combinational)
module m3_sat_ramp_step #(
  parameter int W     = 22,
  parameter int SHIFT = 5,
  parameter int MIN   = 40,
  parameter int MAX   = 4000000
) (
  input  logic [W-1:0] xI,
  input  logic         addI,
  input  logic         subI,
  output logic [W-1:0] yO
);

  localparam logic [W:0] MIN_W = (W+1)'(MIN);
  localparam logic [W:0] MAX_W = (W+1)'(MAX);

  // One extra bit so the sum cannot wrap before the clamp.
  logic [W:0]   wideX;
  logic [W:0]   shifted;
  logic [W:0]   delta;
  logic [W:0]   sum;
  logic [W-1:0] diff;

  always_comb begin
    wideX   = {1'b0, xI};
    shifted = wideX >> SHIFT;
    // Small values would otherwise stall at a zero delta.
    delta   = (shifted == '0) ? (W+1)'(1) : shifted;
    sum     = wideX + delta;
    diff    = xI - delta[W-1:0];
    yO      = xI;
    if (addI && !subI) begin
      yO = (sum > MAX_W) ? MAX_W[W-1:0] : sum[W-1:0];
    end else if (subI && !addI) begin
      // Compare before subtracting so an underflow never reaches yO.
      yO = (wideX < delta + MIN_W) ? MIN_W[W-1:0] : diff;
    end
  end

endmodule

// File: rtl/m3_step_ramp_ctrl.sv
// rtl/m3_step_ramp_ctrl.sv - 3-phase commutation step sequencer with speed/power ramping
//
// Purpose: produces the commutation step index and a per-step strobe, and holds
// the step period and power level under INC/DEC request control. Direction
// changes ramp the period up to its slowest value before the direction flips.
// Ports:
//   clkI, rstI                  : clock, synchronous active-high reset
//   m3startI                    : run enable (level)
//   m3forceStopI                : latched emergency stop (level)
//   m3invRotateI                : requested direction, 0 forward / 1 reverse
//   m3freqINCi / m3freqDECi     : speed up / slow down pulses
//   m3powerINCi / m3powerDECi   : power up / down pulses
//   m3stepO                     : step index 0..STEPS-1
//   m3stepStrobeO               : 1-cycle pulse when m3stepO changed
//   m3periodO                   : step period in clocks
//   m3powerO                    : power level, 0 outside RUN/REVERSE
//   m3runO                      : 1 in RUN and REVERSE
//   m3dirO                      : applied direction
//   m3stateO                    : IDLE=0 RUN=1 REVERSE=2 STOP=3
module m3_step_ramp_ctrl
  import m3_motor_pkg::*;
#(
  parameter int PERIOD_W   = DEF_PERIOD_W,
  parameter int PERIOD_MAX = DEF_PERIOD_MAX,
  parameter int PERIOD_MIN = DEF_PERIOD_MIN,
  parameter int STEPS      = DEF_STEPS,
  parameter int STEP_W     = DEF_STEP_W,
  parameter int RAMP_SHIFT = DEF_RAMP_SHIFT,
  parameter int POWER_W    = DEF_POWER_W,
  parameter int POWER_INIT = DEF_POWER_INIT,
  parameter int POWER_MAX  = DEF_POWER_MAX,
  parameter int POWER_STEP = DEF_POWER_STEP
) (
  input  logic                clkI,
  input  logic                rstI,
  input  logic                m3startI,
  input  logic                m3forceStopI,
  input  logic                m3invRotateI,
  input  logic                m3freqINCi,
  input  logic                m3freqDECi,
  input  logic                m3powerINCi,
  input  logic                m3powerDECi,
  output logic [STEP_W-1:0]   m3stepO,
  output logic                m3stepStrobeO,
  output logic [PERIOD_W-1:0] m3periodO,
  output logic [POWER_W-1:0]  m3powerO,
  output logic                m3runO,
  output logic                m3dirO,
  output logic [1:0]          m3stateO
);

  localparam logic [PERIOD_W-1:0] P_MAX  = PERIOD_W'(PERIOD_MAX);
  localparam logic [POWER_W-1:0]  P_INIT = POWER_W'(POWER_INIT);

  m3State_t            state;
  logic [STEP_W-1:0]   step;
  logic [PERIOD_W-1:0] period;
  logic [PERIOD_W-1:0] remain;
  logic [POWER_W-1:0]  powerReg;
  logic [POWER_W-1:0]  powerOut;
  logic                dir;
  logic                strobe;
  logic                run;

  // Sticky request flags, consumed at the next step boundary.
  logic fIncP, fDecP, pIncP, pDecP;

  logic                freqEn;
  logic                fIncEff, fDecEff, pIncEff, pDecEff;
  logic                reversing;
  logic                boundary;
  logic                atMax;
  logic                rampAdd, rampSub;
  logic [STEP_W-1:0]   stepFwd, stepBwd;
  logic [PERIOD_W-1:0] periodNext;
  logic [POWER_W-1:0]  powerNext;

  always_comb begin
    // Speed requests only count in RUN; in REVERSE they are dropped.
    freqEn    = (state == ST_RUN);
    fIncEff   = freqEn & (fIncP | m3freqINCi);
    fDecEff   = freqEn & (fDecP | m3freqDECi);
    pIncEff   = pIncP | m3powerINCi;
    pDecEff   = pDecP | m3powerDECi;
    // Still slowing down for a pending direction change.
    reversing = (state == ST_REVERSE) && (m3invRotateI != dir);
    boundary  = (remain == PERIOD_W'(1));
    atMax     = (period == P_MAX);
    rampAdd   = reversing | fDecEff;
    rampSub   = ~reversing & fIncEff;
    stepFwd   = (step == STEP_W'(STEPS - 1)) ? '0 : step + STEP_W'(1);
    stepBwd   = (step == '0) ? STEP_W'(STEPS - 1) : step - STEP_W'(1);
    powerNext = POWER_W'(satPower(32'(powerReg), pIncEff, pDecEff, POWER_STEP, POWER_MAX));
  end

  m3_sat_ramp_step #(
    .W     (PERIOD_W),
    .SHIFT (RAMP_SHIFT),
    .MIN   (PERIOD_MIN),
    .MAX   (PERIOD_MAX)
  ) uPeriodRamp (
    .xI   (period),
    .addI (rampAdd),
    .subI (rampSub),
    .yO   (periodNext)
  );

  always_ff @(posedge clkI) begin
    if (rstI) begin
      state    <= ST_IDLE;
      step     <= '0;
      period   <= P_MAX;
      remain   <= P_MAX;
      powerReg <= P_INIT;
      powerOut <= '0;
      dir      <= 1'b0;
      strobe   <= 1'b0;
      run      <= 1'b0;
      fIncP    <= 1'b0;
      fDecP    <= 1'b0;
      pIncP    <= 1'b0;
      pDecP    <= 1'b0;
    end else if (m3forceStopI) begin
      state    <= ST_STOP;
      strobe   <= 1'b0;
      run      <= 1'b0;
      powerOut <= '0;
      fIncP    <= 1'b0;
      fDecP    <= 1'b0;
      pIncP    <= 1'b0;
      pDecP    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          strobe <= 1'b0;
          fIncP  <= 1'b0;
          fDecP  <= 1'b0;
          pIncP  <= 1'b0;
          pDecP  <= 1'b0;
          if (m3startI) begin
            state    <= ST_RUN;
            period   <= P_MAX;
            remain   <= P_MAX;
            powerReg <= P_INIT;
            powerOut <= P_INIT;
            step     <= '0;
            dir      <= m3invRotateI;
            run      <= 1'b1;
          end
        end

        ST_STOP: begin
          strobe   <= 1'b0;
          run      <= 1'b0;
          powerOut <= '0;
          fIncP    <= 1'b0;
          fDecP    <= 1'b0;
          pIncP    <= 1'b0;
          pDecP    <= 1'b0;
          // Requiring start low here forces a fresh start edge after a stop.
          if (!m3startI) begin
            state <= ST_IDLE;
          end
        end

        default: begin
          if (!m3startI) begin
            state    <= ST_IDLE;
            strobe   <= 1'b0;
            run      <= 1'b0;
            powerOut <= '0;
            fIncP    <= 1'b0;
            fDecP    <= 1'b0;
            pIncP    <= 1'b0;
            pDecP    <= 1'b0;
          end else begin
            strobe <= boundary;
            remain <= remain - PERIOD_W'(1);
            fIncP  <= fIncEff;
            fDecP  <= fDecEff;
            pIncP  <= pIncEff;
            pDecP  <= pDecEff;

            if (state == ST_RUN && m3invRotateI != dir) begin
              state <= ST_REVERSE;
            end else if (state == ST_REVERSE && m3invRotateI == dir) begin
              state <= ST_RUN;
            end

            if (boundary) begin
              fIncP    <= 1'b0;
              fDecP    <= 1'b0;
              pIncP    <= 1'b0;
              pDecP    <= 1'b0;
              powerReg <= powerNext;
              powerOut <= powerNext;
              if (reversing && atMax) begin
                // Slow enough: flip direction and step the new way.
                dir    <= m3invRotateI;
                step   <= m3invRotateI ? stepBwd : stepFwd;
                remain <= period;
                state  <= ST_RUN;
              end else begin
                period <= periodNext;
                remain <= periodNext;
                step   <= dir ? stepBwd : stepFwd;
              end
            end
          end
        end
      endcase
    end
  end

  assign m3stepO       = step;
  assign m3stepStrobeO = strobe;
  assign m3periodO     = period;
  assign m3powerO      = powerOut;
  assign m3runO        = run;
  assign m3dirO        = dir;
  assign m3stateO      = state;

endmodule

// File: tb/tb_m3_step_ramp_ctrl.sv
// tb/tb_m3_step_ramp_ctrl.sv - self-checking bench for m3_step_ramp_ctrl
module tb_m3_step_ramp_ctrl;
  import m3_motor_pkg::*;

  localparam int PMAX   = SIM_PERIOD_MAX;
  localparam int PMIN   = 40;
  localparam int NSTEPS = 12;
  localparam int PWMAX  = 1023;
  localparam int PWSTEP = 8;

  logic clkI = 1'b0;
  logic rstI, start, fstop, inv, fInc, fDec, pInc, pDec;
  wire [3:0]  stepO;
  wire        strobeO;
  wire [21:0] periodO;
  wire [9:0]  powerO;
  wire        runO, dirO;
  wire [1:0]  stateO;

  always #5 clkI = ~clkI;

  m3_step_ramp_ctrl #(
    .PERIOD_W(22), .PERIOD_MAX(PMAX), .PERIOD_MIN(PMIN), .STEPS(NSTEPS), .STEP_W(4),
    .RAMP_SHIFT(5), .POWER_W(10), .POWER_INIT(102), .POWER_MAX(PWMAX), .POWER_STEP(PWSTEP)
  ) dut (
    .clkI(clkI), .rstI(rstI), .m3startI(start), .m3forceStopI(fstop), .m3invRotateI(inv),
    .m3freqINCi(fInc), .m3freqDECi(fDec), .m3powerINCi(pInc), .m3powerDECi(pDec),
    .m3stepO(stepO), .m3stepStrobeO(strobeO), .m3periodO(periodO), .m3powerO(powerO),
    .m3runO(runO), .m3dirO(dirO), .m3stateO(stateO)
  );

  int cyc = 0;
  always @(posedge clkI) cyc++;

  int nTests = 0;
  int nFail  = 0;
  int strobeCnt = 0;

  task automatic chk(string name, int act, int exp);
    nTests++;
    if (act != exp) begin
      nFail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int step; int period; int power; int dir; int state; int cyc;
  } exp_t;
  exp_t sbQ[$];
  exp_t monE;

  // Reference model state.
  int mStep, mPeriod, mPower, mDir, mState, mLastCyc, mInv;

  always @(negedge clkI) begin
    if (strobeO) begin
      strobeCnt++;
      if (sbQ.size() == 0) begin
        nTests++;
        nFail++;
        $display("FAIL unexpected_strobe: got strobe at cycle %0d step %0d, expected none", cyc, stepO);
      end else begin
        monE = sbQ.pop_front();
        chk("sb_cycle", cyc, monE.cyc);
        chk("sb_step", int'(stepO), monE.step);
        chk("sb_period", int'(periodO), monE.period);
        chk("sb_power", int'(powerO), monE.power);
        chk("sb_dir", int'(dirO), monE.dir);
        chk("sb_state", int'(stateO), monE.state);
      end
    end
  end

  function automatic int rampD(int p);
    int d = p >> 5;
    return (d < 1) ? 1 : d;
  endfunction

  function automatic int stepMove(int s, int d);
    if (d == 0) return (s == NSTEPS - 1) ? 0 : s + 1;
    return (s == 0) ? NSTEPS - 1 : s - 1;
  endfunction

  // Pulse requests, predict the next boundary, push it, wait for the DUT strobe.
  task automatic stepOnce(bit fi, bit fd, bit pi, bit pd, int ovP, int ovW);
    exp_t e;
    int budget;
    int d;
    if (fi | fd | pi | pd) begin
      @(negedge clkI);
      fInc = fi; fDec = fd; pInc = pi; pDec = pd;
      @(negedge clkI);
      fInc = 0; fDec = 0; pInc = 0; pDec = 0;
    end
    e.cyc = mLastCyc + mPeriod;
    mLastCyc = e.cyc;
    d = rampD(mPeriod);
    if (mState == 2) begin
      if (mPeriod == PMAX) begin
        mDir = mInv;
        mState = 1;
      end else begin
        mPeriod = (mPeriod + d > PMAX) ? PMAX : mPeriod + d;
      end
    end else begin
      if (fi && !fd) mPeriod = (mPeriod - d < PMIN) ? PMIN : mPeriod - d;
      if (fd && !fi) mPeriod = (mPeriod + d > PMAX) ? PMAX : mPeriod + d;
    end
    mStep = stepMove(mStep, mDir);
    if (pi && !pd) mPower = (mPower + PWSTEP > PWMAX) ? PWMAX : mPower + PWSTEP;
    if (pd && !pi) mPower = (mPower < PWSTEP) ? 0 : mPower - PWSTEP;
    if (ovP >= 0) mPeriod = ovP;
    if (ovW >= 0) mPower = ovW;
    e.step = mStep; e.period = mPeriod; e.power = mPower; e.dir = mDir; e.state = mState;
    sbQ.push_back(e);
    budget = e.cyc - cyc + 20;
    while (sbQ.size() != 0 && budget > 0) begin
      @(negedge clkI);
      budget--;
    end
    if (sbQ.size() != 0) begin
      nTests++;
      nFail++;
      $display("FAIL strobe_timeout: got no strobe by cycle %0d, expected one at cycle %0d", cyc, e.cyc);
      sbQ.delete();
    end
  endtask

  typedef struct {
    bit fi; bit fd; bit pi; bit pd; int expPeriod; int expPower;
  } vec_t;
  vec_t vecs[10];

  initial begin
    #950000;
    $display("FAIL watchdog: got no finish by cycle %0d, expected completion", cyc);
    $fatal(1);
  end

  initial begin
    int guard;
    vecs[0] = '{1, 0, 0, 0, 388, 102};
    vecs[1] = '{1, 0, 1, 0, 376, 110};
    vecs[2] = '{0, 1, 0, 0, 387, 110};
    vecs[3] = '{0, 0, 1, 1, 387, 110};
    vecs[4] = '{1, 1, 0, 0, 387, 110};
    vecs[5] = '{0, 0, 0, 1, 387, 102};
    vecs[6] = '{0, 1, 0, 0, 399, 102};
    vecs[7] = '{0, 1, 0, 0, 400, 102};
    vecs[8] = '{0, 1, 0, 0, 400, 102};
    vecs[9] = '{1, 0, 0, 0, 388, 102};

    rstI = 1; start = 0; fstop = 0; inv = 0; fInc = 0; fDec = 0; pInc = 0; pDec = 0;
    repeat (3) @(negedge clkI);
    rstI = 0;
    chk("rst_step", int'(stepO), 0);
    chk("rst_strobe", int'(strobeO), 0);
    chk("rst_period", int'(periodO), PMAX);
    chk("rst_power", int'(powerO), 0);
    chk("rst_run", int'(runO), 0);
    chk("rst_dir", int'(dirO), 0);
    chk("rst_state", int'(stateO), 0);
    @(negedge clkI);
    chk("idle_hold", int'(stateO), 0);

    // Start and twelve plain steps: full revolution back to 0.
    start = 1;
    @(negedge clkI);
    chk("start_run", int'(runO), 1);
    chk("start_state", int'(stateO), 1);
    chk("start_power", int'(powerO), 102);
    mStep = 0; mPeriod = PMAX; mPower = 102; mDir = 0; mState = 1; mInv = 0; mLastCyc = cyc;
    for (int i = 0; i < NSTEPS; i++) stepOnce(0, 0, 0, 0, -1, -1);
    chk("rev_wrap_step", int'(stepO), 0);

    // Hand-computed request table.
    for (int i = 0; i < 10; i++)
      stepOnce(vecs[i].fi, vecs[i].fd, vecs[i].pi, vecs[i].pd, vecs[i].expPeriod, vecs[i].expPower);

    // Speed up to about 200, then reverse.
    guard = 0;
    while (mPeriod > 200 && guard < 60) begin stepOnce(1, 0, 0, 0, -1, -1); guard++; end
    @(negedge clkI);
    inv = 1; mInv = 1;
    @(negedge clkI);
    chk("reverse_enter", int'(stateO), 2);
    mState = 2;
    stepOnce(1, 0, 0, 0, -1, -1);
    guard = 0;
    while (mState == 2 && guard < 80) begin stepOnce(0, 0, 0, 0, -1, -1); guard++; end
    chk("reverse_done_state", int'(stateO), 1);
    chk("reverse_done_dir", int'(dirO), 1);
    chk("reverse_done_period", int'(periodO), PMAX);

    // Request withdrawn while in REVERSE: back to RUN, direction kept.
    @(negedge clkI);
    inv = 0; mInv = 0;
    @(negedge clkI);
    chk("abort_enter", int'(stateO), 2);
    inv = 1; mInv = 1;
    @(negedge clkI);
    chk("abort_state", int'(stateO), 1);
    chk("abort_dir", int'(dirO), 1);
    stepOnce(0, 1, 0, 0, -1, -1);

    // Ramp to the fastest period and the power ceiling, then push both once more.
    guard = 0;
    while ((mPeriod > PMIN || mPower < PWMAX) && guard < 300) begin
      stepOnce(mPeriod > PMIN, 0, mPower < PWMAX, 0, -1, -1);
      guard++;
    end
    stepOnce(1, 0, 1, 0, -1, -1);
    chk("min_period", int'(periodO), PMIN);
    chk("max_power", int'(powerO), PWMAX);
    guard = 0;
    while (mPower > 0 && guard < 200) begin stepOnce(0, 0, 0, 1, -1, -1); guard++; end
    stepOnce(0, 0, 0, 1, -1, -1);
    chk("zero_power", int'(powerO), 0);

    // Force stop latches until start is released.
    @(negedge clkI);
    fstop = 1;
    @(negedge clkI);
    chk("stop_state", int'(stateO), 3);
    chk("stop_power", int'(powerO), 0);
    chk("stop_run", int'(runO), 0);
    guard = strobeCnt;
    repeat (100) @(negedge clkI);
    chk("stop_strobes", strobeCnt - guard, 0);
    chk("stop_step_held", int'(stepO), mStep);
    fstop = 0;
    repeat (3) @(negedge clkI);
    chk("stop_latched", int'(stateO), 3);
    start = 0;
    @(negedge clkI);
    chk("stop_exit", int'(stateO), 0);

    // Restart reverse: reloads, and step wraps 0 -> 11.
    start = 1;
    @(negedge clkI);
    chk("restart_state", int'(stateO), 1);
    chk("restart_period", int'(periodO), PMAX);
    chk("restart_power", int'(powerO), 102);
    chk("restart_dir", int'(dirO), 1);
    mStep = 0; mPeriod = PMAX; mPower = 102; mDir = 1; mState = 1; mLastCyc = cyc;
    stepOnce(0, 0, 0, 0, -1, -1);

    // Reset in the middle of a REVERSE step.
    @(negedge clkI);
    inv = 0;
    @(negedge clkI);
    chk("rst_rev_enter", int'(stateO), 2);
    repeat (50) @(negedge clkI);
    rstI = 1;
    @(negedge clkI);
    chk("rst2_step", int'(stepO), 0);
    chk("rst2_strobe", int'(strobeO), 0);
    chk("rst2_period", int'(periodO), PMAX);
    chk("rst2_power", int'(powerO), 0);
    chk("rst2_run", int'(runO), 0);
    chk("rst2_dir", int'(dirO), 0);
    chk("rst2_state", int'(stateO), 0);
    rstI = 0;
    @(negedge clkI);
    chk("rst2_start", int'(stateO), 1);
    start = 0;
    @(negedge clkI);
    chk("run_to_idle_state", int'(stateO), 0);
    chk("run_to_idle_power", int'(powerO), 0);
    chk("run_to_idle_run", int'(runO), 0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
